// File: rtl/cdb_if.sv
// Common data bus arbiter bundle: FU completion side and CDB broadcast side.
interface cdb_if #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7
);
  localparam int CNT_W = $clog2(NUM_FU) + 1;

  logic [NUM_FU-1:0]            fu_done;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
  logic [NUM_FU-1:0]            fu_queued;
  logic                         cdb_stall;
  logic                         cdb_valid;
  logic [TAG_WIDTH-1:0]         cdb_tag;
  logic [DATA_WIDTH-1:0]        cdb_data;
  logic [CNT_W-1:0]             pending_count;

  modport master (
    output fu_done, fu_result, fu_tag, cdb_stall,
    input  fu_queued, cdb_valid, cdb_tag, cdb_data, pending_count
  );
  modport slave (
    input  fu_done, fu_result, fu_tag, cdb_stall,
    output fu_queued, cdb_valid, cdb_tag, cdb_data, pending_count
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one holding slot per FU, one registered broadcast per cycle.
module cdb_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic                  drain,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  queued,
  output logic                  valid,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic [DATA_WIDTH-1:0] data
);
  // A slot draining this cycle can be refilled on the same edge.
  assign queued = done & ~rst & (~valid | drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (queued) begin
      valid <= 1'b1;
      tag   <= tag_in;
      data  <= data_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7
) (
  input logic  clk,
  input logic  rst,
  cdb_if.slave bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(NUM_FU) + 1;

  logic [NUM_FU-1:0]                 hold_valid, queued, drain, nxt_valid;
  logic [NUM_FU-1:0][TAG_WIDTH-1:0]  hold_tag;
  logic [NUM_FU-1:0][DATA_WIDTH-1:0] hold_data;
  logic [PTR_W-1:0]                  rr_ptr, grant_idx;
  logic                              any_valid;
  logic                              cdb_valid_q;
  logic [TAG_WIDTH-1:0]              cdb_tag_q;
  logic [DATA_WIDTH-1:0]             cdb_data_q;
  logic [CNT_W-1:0]                  pending_q;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_FU) s = s - NUM_FU;
    return PTR_W'(s);
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_FU-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_FU; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Scan from farthest to nearest so the slot closest to rr_ptr wins.
  always_comb begin
    grant_idx = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (hold_valid[wrap_add(rr_ptr, k)]) begin
        grant_idx = wrap_add(rr_ptr, k);
        any_valid = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    assign drain[i] = any_valid & ~bus.cdb_stall & (grant_idx == PTR_W'(i));
    assign nxt_valid[i] = queued[i] | (hold_valid[i] & ~drain[i]);

    cdb_slot #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .done    (bus.fu_done[i]),
      .drain   (drain[i]),
      .tag_in  (bus.fu_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .data_in (bus.fu_result[i*DATA_WIDTH +: DATA_WIDTH]),
      .queued  (queued[i]),
      .valid   (hold_valid[i]),
      .tag     (hold_tag[i]),
      .data    (hold_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      pending_q   <= '0;
    end else begin
      pending_q <= popcnt(nxt_valid);
      if (!bus.cdb_stall) begin
        cdb_valid_q <= any_valid;
        if (any_valid) begin
          cdb_tag_q  <= hold_tag[grant_idx];
          cdb_data_q <= hold_data[grant_idx];
          rr_ptr     <= wrap_add(grant_idx, 1);
        end
      end
    end
  end

  assign bus.fu_queued     = queued;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_tag       = cdb_tag_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.pending_count = pending_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed table, corner sequences, random run vs. reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_if #(.NUM_FU(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
  cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic          m_v [N];
  logic [TW-1:0] m_t [N];
  logic [DW-1:0] m_d [N];
  int            m_rr;
  logic          m_cv;
  logic [TW-1:0] m_ct;
  logic [DW-1:0] m_cd;
  logic [TW+DW-1:0] sb [$];

  // stimulus for the next cycle
  logic [N-1:0]  d_in;
  logic [TW-1:0] t_in [N];
  logic [DW-1:0] r_in [N];

  typedef struct {
    logic         stall;
    logic [N-1:0] done;
    logic [N-1:0] eq;
    logic         ev;
    logic [TW-1:0] et;
    logic [2:0]   ep;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) c++;
    return c;
  endfunction

  // One clock cycle: drive, check combinational acceptance, clock, check registered outputs.
  task automatic step(input logic r, input logic s, output logic [N-1:0] qa);
    int g;
    int idx;
    logic [N-1:0] q;
    rst = r;
    bus.cdb_stall = s;
    bus.fu_done = d_in;
    for (int i = 0; i < N; i++) begin
      bus.fu_tag[i*TW +: TW]    = t_in[i];
      bus.fu_result[i*DW +: DW] = r_in[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (g < 0 && m_v[idx]) g = idx;
    end
    for (int i = 0; i < N; i++) q[i] = d_in[i] & ~r & (~m_v[i] | ((i == g) & ~s));
    qa = bus.fu_queued;
    chk("fu_queued", qa, q);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) begin m_v[i] = 1'b0; m_t[i] = '0; m_d[i] = '0; end
      m_cv = 1'b0; m_ct = '0; m_cd = '0; m_rr = 0;
      sb.delete();
    end else begin
      if (!s) begin
        if (g >= 0) begin
          m_cv = 1'b1; m_ct = m_t[g]; m_cd = m_d[g]; m_v[g] = 1'b0; m_rr = (g + 1) % N;
        end else m_cv = 1'b0;
      end
      for (int i = 0; i < N; i++) if (q[i]) begin
        m_v[i] = 1'b1; m_t[i] = t_in[i]; m_d[i] = r_in[i];
        sb.push_back({t_in[i], r_in[i]});
      end
    end
    #1;
    chk("cdb_valid", bus.cdb_valid, m_cv);
    if (m_cv || r) begin
      chk("cdb_tag", bus.cdb_tag, m_ct);
      chk("cdb_data", bus.cdb_data, m_cd);
    end
    chk("pending_count", bus.pending_count, mcount());
    // every fresh broadcast must match exactly one outstanding acknowledged result
    if (!r && !s && m_cv) begin
      int hit = -1;
      for (int j = 0; j < sb.size(); j++) if (hit < 0 && sb[j] == {bus.cdb_tag, bus.cdb_data}) hit = j;
      checks++;
      if (hit < 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected actual=%0h expected=outstanding", {bus.cdb_tag, bus.cdb_data});
      end else sb.delete(hit);
    end
  endtask

  task automatic clr_in();
    d_in = '0;
    for (int i = 0; i < N; i++) begin t_in[i] = '0; r_in[i] = '0; end
  endtask

  initial begin
    logic [N-1:0] qa;
    for (int i = 0; i < N; i++) begin m_v[i] = 1'b0; m_t[i] = '0; m_d[i] = '0; end
    m_rr = 0; m_cv = 1'b0; m_ct = '0; m_cd = '0;
    clr_in();
    rst = 1'b1;
    bus.cdb_stall = 1'b0;
    bus.fu_done = '0;
    bus.fu_tag = '0;
    bus.fu_result = '0;

    // reset state, fu_done ignored while in reset
    d_in = 4'b1111;
    step(1'b1, 1'b1, qa);
    chk("rst_queued", qa, 4'b0000);
    clr_in();
    step(1'b1, 1'b0, qa);
    chk("rst_valid", bus.cdb_valid, 1'b0);
    chk("rst_tag", bus.cdb_tag, 7'h0);
    chk("rst_pending", bus.pending_count, 3'd0);

    // single FU, 2-cycle latency, one-cycle presentation
    d_in = 4'b0100; t_in[2] = 7'h15; r_in[2] = 32'h0000_00AB;
    step(1'b0, 1'b0, qa);
    chk("single_queued", qa, 4'b0100);
    chk("single_t1_valid", bus.cdb_valid, 1'b0);
    clr_in();
    step(1'b0, 1'b0, qa);
    chk("single_t2_valid", bus.cdb_valid, 1'b1);
    chk("single_t2_tag", bus.cdb_tag, 7'h15);
    chk("single_t2_data", bus.cdb_data, 32'hAB);
    step(1'b0, 1'b0, qa);
    chk("single_t3_valid", bus.cdb_valid, 1'b0);

    // all four FUs at once from rr_ptr=0, then two more to confirm rr_ptr wrapped to 0
    step(1'b1, 1'b0, qa);
    tbl[0] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 7'h0, 3'd4};
    tbl[1] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 7'h1, 3'd3};
    tbl[2] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 7'h2, 3'd2};
    tbl[3] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 7'h3, 3'd1};
    tbl[4] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 7'h4, 3'd0};
    tbl[5] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 7'h0, 3'd0};
    tbl[6] = '{1'b0, 4'b0011, 4'b0011, 1'b0, 7'h0, 3'd2};
    tbl[7] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 7'h1, 3'd1};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 7'h2, 3'd0};
    for (int v = 0; v < 9; v++) begin
      d_in = tbl[v].done;
      for (int i = 0; i < N; i++) begin t_in[i] = TW'(i + 1); r_in[i] = 32'h100 + i; end
      step(1'b0, tbl[v].stall, qa);
      chk("tbl_queued", qa, tbl[v].eq);
      chk("tbl_valid", bus.cdb_valid, tbl[v].ev);
      if (tbl[v].ev) chk("tbl_tag", bus.cdb_tag, tbl[v].et);
      chk("tbl_pending", bus.pending_count, tbl[v].ep);
    end

    // full slot under stall rejects a second result; release drains the old one
    clr_in();
    d_in = 4'b0010; t_in[1] = 7'h31; r_in[1] = 32'h31;
    step(1'b0, 1'b0, qa);
    t_in[1] = 7'h32; r_in[1] = 32'h32;
    step(1'b0, 1'b1, qa);
    chk("full_queued", qa, 4'b0000);
    chk("full_pending", bus.pending_count, 3'd1);
    clr_in();
    step(1'b0, 1'b0, qa);
    chk("full_rel_tag", bus.cdb_tag, 7'h31);
    chk("full_rel_pending", bus.pending_count, 3'd0);

    // drain and refill of the same slot on one edge
    d_in = 4'b0001; t_in[0] = 7'h11; r_in[0] = 32'h11;
    step(1'b0, 1'b0, qa);
    t_in[0] = 7'h7F; r_in[0] = 32'h7F7F;
    step(1'b0, 1'b0, qa);
    chk("refill_queued", qa, 4'b0001);
    chk("refill_first_tag", bus.cdb_tag, 7'h11);
    chk("refill_pending", bus.pending_count, 3'd1);
    clr_in();
    step(1'b0, 1'b0, qa);
    chk("refill_tag", bus.cdb_tag, 7'h7F);
    chk("refill_valid", bus.cdb_valid, 1'b1);

    // stall freezes the broadcast for 3 cycles (rr_ptr is 1 here)
    d_in = 4'b0110; t_in[1] = 7'h09; r_in[1] = 32'h9; t_in[2] = 7'h0A; r_in[2] = 32'hA;
    step(1'b0, 1'b0, qa);
    clr_in();
    step(1'b0, 1'b0, qa);
    chk("stall_pre_tag", bus.cdb_tag, 7'h09);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, qa);
      chk("stall_valid", bus.cdb_valid, 1'b1);
      chk("stall_tag", bus.cdb_tag, 7'h09);
    end
    step(1'b0, 1'b0, qa);
    chk("stall_next_tag", bus.cdb_tag, 7'h0A);
    step(1'b0, 1'b0, qa);
    chk("stall_after_valid", bus.cdb_valid, 1'b0);

    // reset mid-run with two slots held
    d_in = 4'b1100; t_in[2] = 7'h41; t_in[3] = 7'h42;
    step(1'b0, 1'b0, qa);
    chk("midrst_pre_pending", bus.pending_count, 3'd2);
    clr_in();
    step(1'b1, 1'b0, qa);
    chk("midrst_valid", bus.cdb_valid, 1'b0);
    chk("midrst_pending", bus.pending_count, 3'd0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, qa);
      chk("midrst_no_stale", bus.cdb_valid, 1'b0);
    end

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      d_in = N'($urandom);
      for (int i = 0; i < N; i++) begin t_in[i] = TW'($urandom); r_in[i] = $urandom; end
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), qa);
    end
    clr_in();
    for (int c = 0; c < 2 * N; c++) step(1'b0, 1'b0, qa);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_pending", bus.pending_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 4, giving the number of functional units sharing the broadcast bus.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the result width.
REQ-003 The block SHALL have parameter TAG_WIDTH, default 7, giving the execution tag width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fu_done  input  NUM_FU  per-FU one-cycle completion pulse.
REQ-007 fu_result  input  NUM_FU*DATA_WIDTH  per-FU result; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 fu_tag  input  NUM_FU*TAG_WIDTH  per-FU execution tag; slice i analogous.
REQ-009 fu_queued  output  NUM_FU  per-FU acceptance, combinational, valid in the same cycle as fu_done.
REQ-010 cdb_stall  input  1  consumer back-pressure; freezes the broadcast register.
REQ-011 cdb_valid  output  1  registered broadcast valid.
REQ-012 cdb_tag  output  TAG_WIDTH  registered broadcast tag.
REQ-013 cdb_data  output  DATA_WIDTH  registered broadcast result.
REQ-014 pending_count  output  $clog2(NUM_FU)+1  number of occupied holding slots.

Function
REQ-015 The block SHALL contain one holding slot per FU: hold_valid[i], hold_tag[i], hold_data[i].
REQ-016 fu_queued[i] SHALL equal fu_done[i] & ~rst & (~hold_valid[i] | slot_i_drains_this_cycle).
REQ-017 fu_done[i] with fu_queued[i] high SHALL load slot i from fu_tag/fu_result slice i and set hold_valid[i] on the next edge.
REQ-018 fu_done[i] with fu_queued[i] low SHALL be ignored; the FU keeps its result and is not acknowledged.
REQ-019 grant SHALL be one-hot over hold_valid, round-robin, searching from rr_ptr upward with wrap from NUM_FU-1 to 0.
REQ-020 With cdb_stall low and any hold_valid set, the granted slot SHALL load cdb_tag/cdb_data on the next edge, with cdb_valid set.
REQ-021 The granted slot's hold_valid SHALL clear on that edge unless refilled on the same edge per REQ-016, in which case it stays set with the new data.
REQ-022 rr_ptr SHALL update to (granted index + 1) mod NUM_FU on a grant and hold otherwise.
REQ-023 With cdb_stall low and no hold_valid set, cdb_valid SHALL be 0 on the next edge.
REQ-024 With cdb_stall high, cdb_valid/cdb_tag/cdb_data and rr_ptr SHALL hold, no slot SHALL drain, and new captures into empty slots SHALL proceed.
REQ-025 Each broadcast SHALL be presented for exactly one cycle when cdb_stall is low.
REQ-026 Minimum latency SHALL be 2 cycles: fu_done at cycle T, slot at T+1, cdb_valid at T+2.
REQ-027 Simultaneous fu_done on all FUs SHALL all be accepted when all slots are empty; they SHALL broadcast in round-robin order, one per cycle.
REQ-028 pending_count SHALL equal popcount(hold_valid), registered with the slots.
REQ-029 No broadcast SHALL be duplicated or dropped; every acknowledged result SHALL appear on the CDB exactly once.

Reset
REQ-030 rst SHALL clear on the next edge: hold_valid to 0, cdb_valid to 0, cdb_tag to 0, cdb_data to 0, rr_ptr to 0, pending_count to 0.
REQ-031 fu_queued SHALL be 0 while rst is high.
REQ-032 rst asserted mid-operation SHALL discard all held and in-flight results; there SHALL be no broadcast in the cycle after reset.
REQ-033 rst SHALL take priority over fu_done and cdb_stall.

Verification
REQ-034 Single FU: fu_done[2]=1 for 1 cycle with tag 0x15, result 0x0000_00AB at T -> fu_queued[2]=1 at T; cdb_valid=1, tag 0x15, data 0xAB at T+2 only.
REQ-035 All four FUs: fu_done=4'b1111 at T, tags 1..4 -> fu_queued=4'b1111; broadcasts tags 1,2,3,4 at T+2..T+5; rr_ptr=0 afterwards.
REQ-036 Full slot: slot 1 held and cdb_stall=1, fu_done[1]=1 -> fu_queued[1]=0; release stall -> old slot-1 data broadcast, pending_count decrements.
REQ-037 Drain and refill: slot 0 granted this cycle, fu_done[0]=1 with tag 0x7F in the same cycle -> fu_queued[0]=1; tag 0x7F broadcast later; no loss.
REQ-038 Stall: cdb_valid=1, tag 0x09, cdb_stall=1 for 3 cycles -> outputs frozen for 3 cycles; next tag follows the cycle after stall drops.
REQ-039 Reset mid-run: two slots full, rst=1 for 1 cycle -> cdb_valid=0, pending_count=0; no stale tag broadcast afterwards.
